// File: rtl/mcu_core_param.sv
// Parametrised multicycle single-accumulator core with a streaming program
// loader, flag-conditional jumps, halt/illegal trapping and a store strobe.
module mcu_core_param #(
    parameter int DATA_W     = 8,
    parameter int PMEM_DEPTH = 256,
    parameter int DMEM_AW    = 4,
    localparam int IW        = DATA_W + 4,
    localparam int PC_W      = $clog2(PMEM_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load_valid,
    input  logic [IW-1:0]      i_load_instr,
    input  logic               i_load_last,
    output logic               o_load_ready,
    output logic [PC_W-1:0]    o_pc,
    output logic [DATA_W-1:0]  o_acc,
    output logic [3:0]         o_flags,
    output logic [2:0]         o_state,
    output logic               o_halted,
    output logic               o_illegal,
    output logic               o_store_valid,
    output logic [DMEM_AW-1:0] o_store_addr,
    output logic [DATA_W-1:0]  o_store_data
);

    localparam int M = DATA_W - 1;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_HALT = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_JZ   = 4'h3;
    localparam logic [3:0] OP_JC   = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LDM  = 4'h6;
    localparam logic [3:0] OP_STM  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_SUBI = 4'h9;
    localparam logic [3:0] OP_ADDM = 4'hA;
    localparam logic [3:0] OP_SUBM = 4'hB;
    localparam logic [3:0] OP_ANDM = 4'hC;
    localparam logic [3:0] OP_ORM  = 4'hD;
    localparam logic [3:0] OP_XORM = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    logic [IW-1:0]     pmem [PMEM_DEPTH];
    logic [DATA_W-1:0] dmem [2**DMEM_AW];

    state_t            state, state_nx;
    logic [PC_W-1:0]   lptr, pc;
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] dr, acc;
    logic [3:0]        flags;
    logic              illegal;

    logic [3:0]         op;
    logic [DATA_W-1:0]  k, b, res, acc_val;
    logic [DMEM_AW-1:0] a;
    logic [PC_W-1:0]    tgt;
    logic [DATA_W:0]    sum, dif;
    logic               c, v, alu, acc_ld, jump, stop, bad, st;
    logic               xfer, load_done;

    assign op  = ir[IW-1 -: 4];
    assign k   = ir[DATA_W-1:0];
    assign a   = k[DMEM_AW-1:0];
    assign tgt = k[PC_W-1:0];

    assign xfer      = (state == S_LOAD) && i_load_valid;
    assign load_done = xfer && (i_load_last || lptr == PC_W'(PMEM_DEPTH - 1));

    always_comb begin
        b       = (op == OP_ADDI || op == OP_SUBI) ? k : dr;
        sum     = {1'b0, acc} + {1'b0, b};
        dif     = {1'b0, acc} - {1'b0, b};
        res     = '0;
        c       = 1'b0;
        v       = 1'b0;
        alu     = 1'b0;
        acc_ld  = 1'b0;
        acc_val = k;
        jump    = 1'b0;
        stop    = 1'b0;
        bad     = 1'b0;
        st      = 1'b0;
        case (op)
            OP_HALT: stop = 1'b1;
            OP_JMP:  jump = 1'b1;
            OP_JZ:   jump = flags[3];
            OP_JC:   jump = flags[2];
            OP_LDI:  acc_ld = 1'b1;
            OP_LDM: begin
                acc_ld  = 1'b1;
                acc_val = dr;
            end
            OP_STM:  st = 1'b1;
            OP_ADDI, OP_ADDM: begin
                alu = 1'b1;
                res = sum[DATA_W-1:0];
                c   = sum[DATA_W];
                v   = (acc[M] == b[M]) && (res[M] != acc[M]);
            end
            OP_SUBI, OP_SUBM: begin
                alu = 1'b1;
                res = dif[DATA_W-1:0];
                c   = dif[DATA_W];
                v   = (acc[M] != b[M]) && (res[M] != acc[M]);
            end
            OP_ANDM: begin
                alu = 1'b1;
                res = acc & dr;
            end
            OP_ORM: begin
                alu = 1'b1;
                res = acc | dr;
            end
            OP_XORM: begin
                alu = 1'b1;
                res = acc ^ dr;
            end
            OP_ILL: begin
                stop = 1'b1;
                bad  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:    if (load_done) state_nx = S_FETCH;
            S_FETCH:   state_nx = S_DECODE;
            S_DECODE:  state_nx = S_EXECUTE;
            S_EXECUTE: state_nx = stop ? S_HALT : S_FETCH;
            S_HALT:    state_nx = S_HALT;
            default:   state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_LOAD;
        else         state <= state_nx;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lptr          <= '0;
            pc            <= '0;
            ir            <= '0;
            dr            <= '0;
            acc           <= '0;
            flags         <= '0;
            illegal       <= 1'b0;
            o_store_valid <= 1'b0;
            o_store_addr  <= '0;
            o_store_data  <= '0;
        end else begin
            o_store_valid <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (xfer) lptr <= lptr + 1'b1;
                    if (load_done) begin
                        pc    <= '0;
                        ir    <= '0;
                        dr    <= '0;
                        acc   <= '0;
                        flags <= '0;
                    end
                end
                S_FETCH:  ir <= pmem[pc];
                S_DECODE: dr <= dmem[a];
                S_EXECUTE: begin
                    if (!stop) pc <= jump ? tgt : pc + 1'b1;
                    if (acc_ld) acc <= acc_val;
                    if (alu) begin
                        acc   <= res;
                        flags <= {res == '0, c, res[M], v};
                    end
                    if (bad) illegal <= 1'b1;
                    if (st) begin
                        o_store_valid <= 1'b1;
                        o_store_addr  <= a;
                        o_store_data  <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memories have no reset; writes are blocked while reset is held.
    always_ff @(posedge i_clk) begin
        if (!i_reset && xfer) pmem[lptr] <= i_load_instr;
        if (!i_reset && state == S_EXECUTE && st) dmem[a] <= acc;
    end

    assign o_load_ready = (state == S_LOAD);
    assign o_pc         = pc;
    assign o_acc        = acc;
    assign o_flags      = flags;
    assign o_state      = state;
    assign o_halted     = (state == S_HALT);
    assign o_illegal    = illegal;

endmodule

// File: tb/tb_mcu_core_param.sv
// Scoreboard bench for mcu_core_param: an ISA-level model predicts every
// retired instruction and store; a monitor compares what the core shows.
module tb_mcu_core_param;

    localparam int DW = 8;
    localparam int PD = 16;
    localparam int DA = 4;
    localparam int IW = 12;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lvalid = 1'b0;
    logic          llast = 1'b0;
    logic [IW-1:0] linstr = '0;
    logic          load_ready, halted, illegal, store_valid;
    logic [PW-1:0] pc;
    logic [DW-1:0] acc, store_data;
    logic [3:0]    flags;
    logic [2:0]    state;
    logic [DA-1:0] store_addr;

    mcu_core_param #(.DATA_W(DW), .PMEM_DEPTH(PD), .DMEM_AW(DA)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_load_valid(lvalid), .i_load_instr(linstr), .i_load_last(llast),
        .o_load_ready(load_ready), .o_pc(pc), .o_acc(acc), .o_flags(flags),
        .o_state(state), .o_halted(halted), .o_illegal(illegal),
        .o_store_valid(store_valid), .o_store_addr(store_addr),
        .o_store_data(store_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [DW-1:0] acc;
        logic [3:0]    flags;
        logic          halted;
        logic          illegal;
    } ret_t;

    typedef struct packed {
        logic [DA-1:0] addr;
        logic [DW-1:0] data;
    } st_t;

    ret_t exp_q[$];
    st_t  st_q[$];
    int vectors = 0;
    int errors  = 0;
    int xfers   = 0;

    logic [IW-1:0] mp [PD];
    logic [DW-1:0] dm [2**DA];
    logic [IW-1:0] prog [PD];
    int            m_n, m_pc, m_acc;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // ISA interpreter: runs the program in mp from PC 0 with cleared state.
    task automatic run_model(input int max_steps);
        int p, ac, z, cy, n, ov, op, kk, ad, b, r, s, np, hl, il;
        logic [IW-1:0] w;
        ret_t e;
        st_t  sv;
        p = 0; ac = 0; z = 0; cy = 0; n = 0; ov = 0;
        m_n = 0;
        for (int step = 0; step < max_steps; step++) begin
            w  = mp[p];
            op = int'(w[11:8]);
            kk = int'(w[7:0]);
            ad = kk % (2**DA);
            np = (p + 1) % PD;
            hl = 0; il = 0;
            b  = (op == 8 || op == 9) ? kk : int'(dm[ad]);
            case (op)
                1: begin hl = 1; np = p; end
                2: np = kk % PD;
                3: if (z != 0) np = kk % PD;
                4: if (cy != 0) np = kk % PD;
                5: ac = kk;
                6: ac = int'(dm[ad]);
                7: begin
                    dm[ad] = DW'(ac);
                    sv.addr = DA'(ad);
                    sv.data = DW'(ac);
                    st_q.push_back(sv);
                end
                8, 10: begin
                    r  = ac + b;
                    s  = sgn(ac) + sgn(b);
                    cy = (r > 255) ? 1 : 0;
                    ov = (s > 127 || s < -128) ? 1 : 0;
                    ac = r % 256;
                end
                9, 11: begin
                    s  = sgn(ac) - sgn(b);
                    cy = (ac < b) ? 1 : 0;
                    ov = (s > 127 || s < -128) ? 1 : 0;
                    ac = (ac - b + 256) % 256;
                end
                12, 13, 14: begin
                    if (op == 12) ac = ac & b;
                    else if (op == 13) ac = ac | b;
                    else ac = ac ^ b;
                    cy = 0; ov = 0;
                end
                15: begin hl = 1; il = 1; np = p; end
                default: ;
            endcase
            if (op >= 8 && op <= 14) begin
                z = (ac == 0) ? 1 : 0;
                n = (ac > 127) ? 1 : 0;
            end
            p = np;
            e.pc      = PW'(p);
            e.acc     = DW'(ac);
            e.flags   = {z[0], cy[0], n[0], ov[0]};
            e.halted  = hl[0];
            e.illegal = il[0];
            exp_q.push_back(e);
            m_n++;
            if (hl != 0) break;
        end
        m_pc = p;
        m_acc = ac;
    endtask

    always @(posedge clk) if (lvalid && load_ready) xfers++;

    logic [2:0] prev_state = 3'd0;
    ret_t e_m;
    st_t  s_m;
    always @(negedge clk) begin
        if (!rst && prev_state == 3'd3 && state != 3'd3) begin
            if (exp_q.size() == 0) begin
                vectors++; errors++;
                $display("FAIL retire: unexpected at pc %0h", pc);
            end else begin
                e_m = exp_q.pop_front();
                check("ret_pc", 32'(pc), 32'(e_m.pc));
                check("ret_acc", 32'(acc), 32'(e_m.acc));
                check("ret_flags", 32'(flags), 32'(e_m.flags));
                check("ret_halted", 32'(halted), 32'(e_m.halted));
                check("ret_illegal", 32'(illegal), 32'(e_m.illegal));
            end
        end
        if (store_valid) begin
            if (st_q.size() == 0) begin
                vectors++; errors++;
                $display("FAIL store: unexpected addr %0h data %0h", store_addr, store_data);
            end else begin
                s_m = st_q.pop_front();
                check("store_addr", 32'(store_addr), 32'(s_m.addr));
                check("store_data", 32'(store_data), 32'(s_m.data));
            end
        end
        prev_state = state;
    end

    task automatic reset_checks();
        check("rst_state", 32'(state), 0);
        check("rst_ready", 32'(load_ready), 1);
        check("rst_pc", 32'(pc), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_store", {store_valid, 4'(store_addr), 8'(store_data)}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        reset_checks();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load(input int n, input bit use_last);
        xfers = 0;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 2) == 0) begin
                lvalid = 1'b0;
                linstr = IW'($urandom);
                @(posedge clk);
                #1;
            end
            lvalid = 1'b1;
            linstr = prog[i];
            llast  = use_last && (i == n - 1);
            @(posedge clk);
            #1;
        end
        lvalid = 1'b0;
        llast  = 1'b0;
        check("load_xfers", 32'(xfers), 32'(n));
        check("load_ready_drop", 32'(load_ready), 0);
        check("load_state", 32'(state), 1);
        check("load_pc", 32'(pc), 0);
    endtask

    task automatic wait_halt(input int n);
        int cyc;
        cyc = 0;
        while (!halted && cyc < 1000) begin
            lvalid = 1'($urandom_range(0, 1));
            linstr = IW'($urandom);
            @(posedge clk);
            #1;
            cyc++;
        end
        lvalid = 1'b0;
        check("halt_cycles", 32'(cyc), 32'(3 * m_n));
        @(negedge clk);
        #1;
        check("retire_drain", 32'(exp_q.size()), 0);
        check("store_drain", 32'(st_q.size()), 0);
        repeat (4) @(posedge clk);
        #1;
        check("final_pc", 32'(pc), 32'(m_pc));
        check("final_acc", 32'(acc), 32'(m_acc));
        check("final_halted", 32'(halted), 1);
        check("final_ready", 32'(load_ready), 0);
        check("ignored_load", 32'(xfers), 32'(n));
        exp_q.delete();
        st_q.delete();
    endtask

    task automatic run_prog(input int n, input bit use_last);
        do_reset();
        for (int i = 0; i < n; i++) mp[i] = prog[i];
        run_model(200);
        load(n, use_last);
        wait_halt(n);
    endtask

    initial begin
        int cyc, len, op, cnt;

        // Directed programs
        prog[0] = 12'h57F; prog[1] = 12'h801; prog[2] = 12'h100;
        run_prog(3, 1);
        prog[0] = 12'h500; prog[1] = 12'h901; prog[2] = 12'h100;
        run_prog(3, 1);
        prog[0] = 12'h5A5; prog[1] = 12'h705; prog[2] = 12'h500;
        prog[3] = 12'hA05; prog[4] = 12'h100;
        run_prog(5, 1);
        prog[0] = 12'h503; prog[1] = 12'h901; prog[2] = 12'h306;
        prog[3] = 12'h201; prog[4] = 12'h000; prog[5] = 12'h000;
        prog[6] = 12'h100;
        run_prog(7, 1);
        prog[0] = 12'hF00;
        run_prog(1, 1);

        // Give every data word a known value
        for (int base = 0; base < 16; base += 7) begin
            cnt = (16 - base < 7) ? 16 - base : 7;
            for (int j = 0; j < cnt; j++) begin
                prog[2*j]   = {4'h5, 8'($urandom)};
                prog[2*j+1] = {4'h7, 8'(base + j)};
            end
            prog[2*cnt] = 12'h100;
            run_prog(2 * cnt + 1, 1);
        end

        // Reset during EXECUTE of a store must suppress it
        do_reset();
        prog[0] = 12'h53C; prog[1] = 12'h702; prog[2] = 12'h100;
        for (int i = 0; i < 3; i++) mp[i] = prog[i];
        run_model(1);
        load(3, 1);
        cyc = 0;
        while (!(state == 3'd3 && pc == 4'd1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reach", 32'(cyc < 20), 1);
        #1 rst = 1'b1;
        #1 reset_checks();
        @(posedge clk);
        @(negedge clk);
        #1;
        check("abort_no_store", 32'(store_valid), 0);
        check("abort_retire", 32'(exp_q.size()), 0);
        rst = 1'b0;
        exp_q.delete();
        st_q.delete();
        prog[0] = 12'h602; prog[1] = 12'h100;
        run_prog(2, 1);

        // Random programs with forward-only jumps
        for (int t = 0; t < 40; t++) begin
            len = (t % 5 == 4) ? 16 : int'($urandom_range(2, 15));
            for (int i = 0; i < len - 1; i++) begin
                op = int'($urandom_range(0, 15));
                if ((op == 1 || op == 15) && $urandom_range(0, 3) != 0) op = 8;
                if (op >= 2 && op <= 4)
                    prog[i] = {4'(op), 8'($urandom_range(len - 1, i + 1))};
                else
                    prog[i] = {4'(op), 8'($urandom)};
            end
            prog[len-1] = 12'h100;
            run_prog(len, len != 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
